mac_dot_driver: RTL and testbench

Initiator for the mac_pipeline operand interface. It computes a signed dot product of up to MAX_LEN operand pairs held in a local buffer. Each step issues one MAC transaction (in_valid/a/b/acc), waits for out_valid/y, and feeds y back as the next acc. It sits between the host/control logic and a mac_pipeline instance and turns a vector request into a chained, serialised MAC sequence.

---
 rtl/mac_dot_driver.sv | 126 ++++++++++++
 tb/tb_mac_dot_driver.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_driver.sv
// Dot-product initiator for a mac_pipeline: walks a local operand buffer, issues one
// MAC transaction per element and chains each response back as the next accumulator.
module mac_dot_driver #(
    parameter int DW      = 8,
    parameter int AW      = 32,
    parameter int MAX_LEN = 16,
    parameter int LW      = 5,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ld_en,
    input  logic [$clog2(MAX_LEN)-1:0] ld_addr,
    input  logic [DW-1:0]              ld_a,
    input  logic [DW-1:0]              ld_b,
    input  logic                       start,
    input  logic [LW-1:0]              len,
    input  logic [AW-1:0]              init_acc,
    output logic                       busy,
    output logic                       done,
    output logic [AW-1:0]              result,
    output logic                       err,
    output logic                       mac_in_valid,
    output logic [DW-1:0]              mac_a,
    output logic [DW-1:0]              mac_b,
    output logic [AW-1:0]              mac_acc,
    input  logic                       mac_out_valid,
    input  logic [AW-1:0]              mac_y
);

    localparam int IW = $clog2(MAX_LEN);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

    state_t        state;
    logic [DW-1:0] buf_a [MAX_LEN];
    logic [DW-1:0] buf_b [MAX_LEN];
    logic [LW-1:0] len_reg;
    logic [LW-1:0] idx;
    logic [LW-1:0] len_clamped;
    logic [AW-1:0] acc_reg;
    logic [TW-1:0] tcnt;

    always_comb begin
        len_clamped = (len > MAX_LEN_L) ? MAX_LEN_L : len;
    end

    // NOTE: the operand buffer has no reset; its contents are only meaningful once loaded,
    // and leaving it out of reset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (ld_en && !busy && state == IDLE) begin
            buf_a[ld_addr] <= ld_a;
            buf_b[ld_addr] <= ld_b;
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            mac_in_valid <= 1'b0;
            mac_a        <= '0;
            mac_b        <= '0;
            mac_acc      <= '0;
            result       <= '0;
            acc_reg      <= '0;
            len_reg      <= '0;
            idx          <= '0;
            tcnt         <= '0;
        end else begin
            done         <= 1'b0;
            err          <= 1'b0;
            mac_in_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // busy still high here means this is the done/err cycle; start is ignored
                    busy <= 1'b0;
                    if (mac_out_valid) err <= 1'b1;
                    if (start && !busy) begin
                        acc_reg <= init_acc;
                        idx     <= '0;
                        len_reg <= len_clamped;
                        busy    <= 1'b1;
                        state   <= (len_clamped == '0) ? FINISH : ISSUE;
                    end
                end
                ISSUE: begin
                    if (mac_out_valid) err <= 1'b1;
                    mac_in_valid <= 1'b1;
                    mac_a        <= buf_a[idx[IW-1:0]];
                    mac_b        <= buf_b[idx[IW-1:0]];
                    mac_acc      <= acc_reg;
                    tcnt         <= '0;
                    state        <= WAIT;
                end
                WAIT: begin
                    if (mac_out_valid) begin
                        acc_reg <= mac_y;
                        idx     <= idx + LW'(1);
                        state   <= (idx + LW'(1) == len_reg) ? FINISH : ISSUE;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        // abandon the sequence; busy drops after this err cycle
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                FINISH: begin
                    if (mac_out_valid) err <= 1'b1;
                    result <= acc_reg;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_dot_driver.sv
// Directed bench for mac_dot_driver with a behavioural MAC of selectable latency.
module tb_mac_dot_driver;

    logic               clk = 1'b0;
    logic               rst;
    logic               ld_en;
    logic [3:0]         ld_addr;
    logic signed [7:0]  ld_a;
    logic signed [7:0]  ld_b;
    logic               start;
    logic [4:0]         len;
    logic signed [31:0] init_acc;
    logic               busy;
    logic               done;
    logic [31:0]        result;
    logic               err;
    logic               mac_in_valid;
    logic signed [7:0]  mac_a;
    logic signed [7:0]  mac_b;
    logic signed [31:0] mac_acc;
    logic               mac_out_valid;
    logic signed [31:0] mac_y;

    int checks = 0;
    int errors = 0;

    mac_dot_driver dut (
        .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_a(ld_a), .ld_b(ld_b),
        .start(start), .len(len), .init_acc(init_acc), .busy(busy), .done(done),
        .result(result), .err(err), .mac_in_valid(mac_in_valid), .mac_a(mac_a),
        .mac_b(mac_b), .mac_acc(mac_acc), .mac_out_valid(mac_out_valid), .mac_y(mac_y)
    );

    always #5 clk = ~clk;

    // Behavioural MAC: y = a*b + acc, returned lat cycles after in_valid.
    int                 lat = 2;
    logic               mac_en = 1'b1;
    logic               spur = 1'b0;
    logic [3:0]         pv;
    logic signed [31:0] py [4];
    logic signed [31:0] prod;

    assign prod = mac_a * mac_b + mac_acc;

    always @(posedge clk) begin
        if (rst) begin
            pv <= '0;
        end else begin
            pv    <= {pv[2:0], mac_in_valid};
            py[0] <= prod;
            py[1] <= py[0];
            py[2] <= py[1];
            py[3] <= py[2];
        end
    end

    assign mac_out_valid = (mac_en && pv[lat-1]) || spur;
    assign mac_y         = py[lat-1];

    // Monitors: log mac_acc per issued transaction, count done/err pulses.
    logic [31:0] acc_log [256];
    int n_iv = 0;
    int n_done = 0;
    int n_err = 0;

    always @(posedge clk) begin
        if (mac_in_valid) begin
            acc_log[n_iv[7:0]] <= mac_acc;
            n_iv <= n_iv + 1;
        end
        if (done) n_done <= n_done + 1;
        if (err)  n_err  <= n_err + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, $signed(got), got,
                     $signed(exp), exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load(input logic [3:0] addr, input logic signed [7:0] a,
                        input logic signed [7:0] b);
        ld_en = 1'b1; ld_addr = addr; ld_a = a; ld_b = b;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic do_start(input logic [4:0] l, input logic signed [31:0] ia);
        start = 1'b1; len = l; init_acc = ia;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget, output int cyc, output bit got_done,
                            output bit got_err);
        got_done = 1'b0;
        got_err  = 1'b0;
        for (cyc = 0; cyc <= budget; cyc++) begin
            if (done || err) begin
                got_done = done;
                got_err  = err;
                break;
            end
            tick();
        end
    endtask

    int base, base_done, base_err, cyc;
    bit gd, ge;

    initial begin
        rst = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_a = '0; ld_b = '0;
        start = 1'b0; len = '0; init_acc = '0;
        tick(); tick();
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_err", {31'b0, err}, 0);
        check("rst_in_valid", {31'b0, mac_in_valid}, 0);
        check("rst_result", result, 0);
        check("rst_mac_acc", mac_acc, 0);
        rst = 1'b0;
        tick();

        // Basic 3-element dot product, MAC latency 2: 10+12=22, 22-14=8, 8+64=72.
        load(4'd0, 8'sd3, 8'sd4);
        load(4'd1, -8'sd2, 8'sd7);
        load(4'd2, 8'sd8, 8'sd8);
        base = n_iv; base_done = n_done;
        do_start(5'd3, 32'sd10);
        wait_end(200, cyc, gd, ge);
        check("basic_done_seen", {31'b0, gd}, 1);
        check("basic_result", result, 72);
        check("basic_busy_in_done", {31'b0, busy}, 1);
        tick();
        check("basic_busy_after", {31'b0, busy}, 0);
        tick();
        check("basic_in_valid_cnt", n_iv - base, 3);
        check("basic_acc0", acc_log[base], 10);
        check("basic_acc1", acc_log[base+1], 22);
        check("basic_acc2", acc_log[base+2], 8);
        check("basic_done_cnt", n_done - base_done, 1);

        // Zero length: no MAC traffic, done within 2 cycles, result = init_acc.
        base = n_iv;
        do_start(5'd0, -32'sd5);
        wait_end(2, cyc, gd, ge);
        check("len0_done_seen", {31'b0, gd}, 1);
        check("len0_result", result, -32'sd5);
        tick(); tick();
        check("len0_in_valid_cnt", n_iv - base, 0);

        // Silent MAC: timeout err, no done, result untouched.
        mac_en = 1'b0;
        base_done = n_done; base_err = n_err;
        do_start(5'd2, 32'sd1000);
        wait_end(200, cyc, gd, ge);
        check("tmo_err_seen", {31'b0, ge}, 1);
        check("tmo_wait_long", {31'b0, cyc >= 64}, 1);
        tick();
        check("tmo_busy_after", {31'b0, busy}, 0);
        tick();
        check("tmo_result_kept", result, -32'sd5);
        check("tmo_done_cnt", n_done - base_done, 0);
        check("tmo_err_cnt", n_err - base_err, 1);
        mac_en = 1'b1;
        tick(); tick();

        // Start and buffer write while busy must both be ignored.
        base = n_iv;
        do_start(5'd3, 32'sd10);
        tick(); tick(); tick();
        ld_en = 1'b1; ld_addr = 4'd1; ld_a = 8'sd100; ld_b = 8'sd100;
        start = 1'b1; len = 5'd1; init_acc = 32'sd0;
        tick();
        ld_en = 1'b0; start = 1'b0;
        wait_end(200, cyc, gd, ge);
        check("busy_ign_done", {31'b0, gd}, 1);
        check("busy_ign_result", result, 72);
        tick(); tick(); tick();
        check("busy_ign_in_valid_cnt", n_iv - base, 3);

        // Reset while waiting on step 2, then a clean rerun.
        base = n_iv;
        do_start(5'd3, 32'sd10);
        for (int i = 0; i < 50; i++) begin
            if (n_iv - base == 2) break;
            tick();
        end
        check("rst_mid_reached_step2", n_iv - base, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_busy", {31'b0, busy}, 0);
        check("rst_mid_in_valid", {31'b0, mac_in_valid}, 0);
        check("rst_mid_result", result, 0);
        tick();
        do_start(5'd3, 32'sd10);
        wait_end(200, cyc, gd, ge);
        check("rst_rerun_result", result, 72);
        tick(); tick();

        // Full buffer of (127,127), MAC latency 1, len=20 clamps to 16.
        lat = 1;
        for (int i = 0; i < 16; i++) load(4'(i), 8'sd127, 8'sd127);
        base = n_iv;
        do_start(5'd20, 32'sd0);
        wait_end(400, cyc, gd, ge);
        check("max_done_seen", {31'b0, gd}, 1);
        check("max_result", result, 258064);
        tick(); tick();
        check("max_in_valid_cnt", n_iv - base, 16);
        check("max_last_acc", acc_log[base+15], 241935);

        // Spurious response in IDLE: err only.
        base_done = n_done; base_err = n_err;
        spur = 1'b1;
        tick();
        check("spur_err_pulse", {31'b0, err}, 1);
        spur = 1'b0;
        tick();
        check("spur_err_clear", {31'b0, err}, 0);
        tick();
        check("spur_err_cnt", n_err - base_err, 1);
        check("spur_done_cnt", n_done - base_done, 0);
        check("spur_result", result, 258064);
        check("spur_busy", {31'b0, busy}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
